// File: rtl/mem_bus_initiator.sv
// Core-side load/store initiator driving a waitrequest-style memory bus.
// Optional waitrequest stall timeout is enabled by defining BUS_TIMEOUT_EN.
module mem_bus_initiator #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] address,
    output logic        read,
    output logic        write,
    output logic [31:0] writedata,
    output logic [3:0]  byteenable,
    input  logic        waitrequest,
    input  logic [31:0] readdata
);

    typedef enum logic [2:0] {IDLE, WRITE, READ, RDATA, RESP} state_t;

    state_t      state, state_next;
    logic [31:0] addr_q, wdata_q, rdata_q;
    logic [1:0]  size_q;
    logic        write_q, signed_q, err_q, hold_q;
    logic        accept, legal, timeout, bus_phase;
    logic [3:0]  be_calc;
    logic [31:0] lane_mask, wrep, shifted, load_val;

    assign req_ready = reset && (state == IDLE);
    assign accept    = req_valid && req_ready;
    assign bus_phase = (state == WRITE) || (state == READ) || (state == RDATA);

    always_comb begin
        legal = 1'b0;
        case (req_size)
            2'b00:   legal = 1'b1;
            2'b01:   legal = !req_addr[0];
            2'b10:   legal = (req_addr[1:0] == 2'b00);
            default: legal = 1'b0;
        endcase
    end

`ifdef BUS_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [CNT_W-1:0] stall_cnt;

    // Cleared while idle so every WRITE/READ starts from zero.
    always_ff @(posedge clk) begin
        if (!reset || state == IDLE) begin
            stall_cnt <= '0;
        end else if ((state == WRITE || state == READ) && waitrequest) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

    assign timeout = (state == WRITE || state == READ) && waitrequest &&
                     (stall_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign timeout            = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (!legal)         state_next = RESP;
                    else if (req_write) state_next = WRITE;
                    else                state_next = READ;
                end
            end
            WRITE:   if (timeout || !waitrequest) state_next = RESP;
            READ: begin
                if (!waitrequest)  state_next = RDATA;
                else if (timeout)  state_next = RESP;
            end
            RDATA:   state_next = RESP;
            RESP:    if (!hold_q) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // A rejected request spends one silent cycle in RESP (hold_q) so its
    // response latency matches that of a zero-wait store.
    always_ff @(posedge clk) begin
        if (!reset) begin
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            size_q   <= '0;
            write_q  <= 1'b0;
            signed_q <= 1'b0;
            err_q    <= 1'b0;
            hold_q   <= 1'b0;
        end else begin
            if (accept) begin
                addr_q   <= req_addr;
                wdata_q  <= req_wdata;
                size_q   <= req_size;
                write_q  <= req_write;
                signed_q <= req_signed;
                err_q    <= !legal;
                hold_q   <= !legal;
                rdata_q  <= '0;
            end
            if (state == RDATA) rdata_q <= load_val;
            if (state == RESP)  hold_q  <= 1'b0;
            if (timeout)        err_q   <= 1'b1;
        end
    end

    always_comb begin
        be_calc = 4'b1111;
        wrep    = wdata_q;
        case (size_q)
            2'b00: begin
                be_calc = 4'b0001 << addr_q[1:0];
                wrep    = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                be_calc = 4'b0011 << addr_q[1:0];
                wrep    = {2{wdata_q[15:0]}};
            end
            default: begin
                be_calc = 4'b1111;
                wrep    = wdata_q;
            end
        endcase
    end

    assign lane_mask = {{8{be_calc[3]}}, {8{be_calc[2]}}, {8{be_calc[1]}}, {8{be_calc[0]}}};
    assign shifted   = readdata >> {addr_q[1:0], 3'b000};

    always_comb begin
        load_val = shifted;
        case (size_q)
            2'b00:   load_val = {{24{signed_q & shifted[7]}}, shifted[7:0]};
            2'b01:   load_val = {{16{signed_q & shifted[15]}}, shifted[15:0]};
            default: load_val = shifted;
        endcase
    end

    assign address    = {addr_q[31:2], 2'b00};
    assign read       = (state == READ);
    assign write      = (state == WRITE);
    assign byteenable = bus_phase ? be_calc : 4'b0000;
    assign writedata  = (bus_phase && write_q) ? (wrep & lane_mask) : 32'h0;
    assign resp_valid = (state == RESP) && !hold_q;
    assign resp_err   = resp_valid && err_q;
    assign resp_rdata = resp_valid ? rdata_q : 32'h0;

endmodule

// File: tb/tb_mem_bus_initiator.sv
// Scoreboard bench for mem_bus_initiator: the driver queues expected responses,
// a negedge monitor pops and checks them; BUS_TIMEOUT_EN adds the timeout case.
module tb_mem_bus_initiator;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_write, req_signed;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        req_ready, resp_valid, resp_err;
    logic [31:0] resp_rdata, address, writedata, readdata;
    logic        read, write, waitrequest;
    logic [3:0]  byteenable;
    logic [31:0] rsp_word;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int cyc       = 0;

    typedef struct {
        logic [31:0] rd;
        logic        err;
        int          lat;
        int          acc;
    } exp_t;
    exp_t sb[$];

    mem_bus_initiator #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_write(req_write),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_ready(req_ready), .resp_valid(resp_valid),
        .resp_rdata(resp_rdata), .resp_err(resp_err), .address(address),
        .read(read), .write(write), .writedata(writedata), .byteenable(byteenable),
        .waitrequest(waitrequest), .readdata(readdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Registered responder: data appears the cycle after the accepting edge.
    always @(posedge clk) begin
        if (read && !waitrequest) readdata <= rsp_word;
        else                      readdata <= 32'h5A5A5A5A;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    always @(negedge clk) begin
        exp_t e;
        chk("rw_exclusive", {31'd0, read && write}, 32'd0);
        if (resp_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_resp", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("resp_rdata", resp_rdata, e.rd);
                chk("resp_err", {31'd0, resp_err}, {31'd0, e.err});
                chk("resp_latency", 32'(cyc - e.acc + 1), 32'(e.lat));
            end
        end
    end

    task automatic do_req(input logic w, input logic [1:0] sz, input logic sg,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] exp_rd, input logic exp_err,
                          input int exp_lat, input bit push);
        exp_t e;
        int n = 0;
        @(negedge clk);
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("req_ready_before_issue", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg;
        req_addr = a; req_wdata = wd;
        @(posedge clk);
        if (push) begin
            e.rd = exp_rd; e.err = exp_err; e.lat = exp_lat; e.acc = cyc + 1;
            sb.push_back(e);
        end
        #1 req_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(negedge clk);
            #1 n++;
        end
        chk("drain_timeout", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
        req_signed = 1'b0; req_addr = '0; req_wdata = '0; waitrequest = 1'b0;
        rsp_word = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
        chk("rst_read_write", {30'd0, read, write}, 32'd0);
        chk("rst_address", address, 32'd0);
        chk("rst_writedata", writedata, 32'd0);
        chk("rst_byteenable", {28'd0, byteenable}, 32'd0);
        chk("rst_resp", {resp_rdata[30:0], resp_valid | resp_err | resp_rdata[31]}, 32'd0);
        reset = 1'b1;
        @(posedge clk);
        #1 chk("ready_after_release", {31'd0, req_ready}, 32'd1);

        // Word store, no wait
        do_req(1'b1, 2'b10, 1'b0, 32'hBFC00100, 32'hDEADBEEF, 32'h0, 1'b0, 2, 1'b1);
        chk("st_write", {30'd0, read, write}, 32'd1);
        chk("st_be", {28'd0, byteenable}, 32'hF);
        chk("st_address", address, 32'hBFC00100);
        chk("st_wdata", writedata, 32'hDEADBEEF);
        wait_drain();

        // Signed and unsigned byte load from lane 3
        rsp_word = 32'h80112233;
        do_req(1'b0, 2'b00, 1'b1, 32'hBFC00103, 32'h0, 32'hFFFFFF80, 1'b0, 3, 1'b1);
        chk("lb_read", {30'd0, read, write}, 32'd2);
        chk("lb_be", {28'd0, byteenable}, 32'h8);
        chk("lb_wdata_zero", writedata, 32'h0);
        wait_drain();
        do_req(1'b0, 2'b00, 1'b0, 32'hBFC00103, 32'h0, 32'h00000080, 1'b0, 3, 1'b1);
        wait_drain();
        do_req(1'b0, 2'b01, 1'b1, 32'hBFC00102, 32'h0, 32'hFFFF8011, 1'b0, 3, 1'b1);
        chk("lh_be", {28'd0, byteenable}, 32'hC);
        wait_drain();

        // Halfword store with three stall cycles
        waitrequest = 1'b1;
        do_req(1'b1, 2'b01, 1'b0, 32'hBFC00102, 32'h0000ABCD, 32'h0, 1'b0, 5, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("sh_stall_write", {30'd0, read, write}, 32'd1);
            chk("sh_stall_be", {28'd0, byteenable}, 32'hC);
            chk("sh_stall_wdata", writedata, 32'hABCD0000);
            chk("sh_stall_addr", address, 32'hBFC00100);
            @(posedge clk);
        end
        #1 waitrequest = 1'b0;
        wait_drain();

        // Byte store to lane 1
        do_req(1'b1, 2'b00, 1'b0, 32'h00000101, 32'h000000A5, 32'h0, 1'b0, 2, 1'b1);
        chk("sb_be", {28'd0, byteenable}, 32'h2);
        chk("sb_wdata", writedata, 32'h0000A500);
        wait_drain();

        // Misaligned word load, misaligned halfword, illegal size
        do_req(1'b0, 2'b10, 1'b0, 32'hBFC00101, 32'h0, 32'h0, 1'b1, 2, 1'b1);
        chk("mis_no_strobe0", {30'd0, read, write}, 32'd0);
        @(negedge clk);
        chk("mis_no_strobe1", {30'd0, read, write}, 32'd0);
        chk("mis_be", {28'd0, byteenable}, 32'd0);
        wait_drain();
        do_req(1'b1, 2'b01, 1'b0, 32'h00000011, 32'h1234, 32'h0, 1'b1, 2, 1'b1);
        chk("mis_h_no_strobe", {30'd0, read, write}, 32'd0);
        wait_drain();
        do_req(1'b0, 2'b11, 1'b0, 32'h00000020, 32'h0, 32'h0, 1'b1, 2, 1'b1);
        wait_drain();

        // Request presented while busy must be dropped
        waitrequest = 1'b1;
        do_req(1'b1, 2'b10, 1'b0, 32'h00000010, 32'h11223344, 32'h0, 1'b0, 4, 1'b1);
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h00000020; req_size = 2'b10;
        chk("busy_not_ready", {31'd0, req_ready}, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1 waitrequest = 1'b0;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        wait_drain();
        repeat (4) @(negedge clk);

        // Reset during a read stall: access abandoned, no response
        waitrequest = 1'b1;
        do_req(1'b0, 2'b10, 1'b0, 32'h00000040, 32'h0, 32'h0, 1'b0, 0, 1'b0);
        @(negedge clk);
        chk("rst_mid_read_before", {31'd0, read}, 32'd1);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_mid_read", {31'd0, read}, 32'd0);
        chk("rst_mid_be", {28'd0, byteenable}, 32'd0);
        chk("rst_mid_resp", {31'd0, resp_valid}, 32'd0);
        @(negedge clk);
        reset = 1'b1; waitrequest = 1'b0;
        @(posedge clk);
        #1 chk("rst_mid_ready", {31'd0, req_ready}, 32'd1);
        repeat (4) @(negedge clk);

`ifdef BUS_TIMEOUT_EN
        waitrequest = 1'b1;
        do_req(1'b0, 2'b10, 1'b0, 32'h00000080, 32'h0, 32'h0, 1'b1, 5, 1'b1);
        repeat (3) @(posedge clk);
        #1 chk("to_read_held", {31'd0, read}, 32'd1);
        @(posedge clk);
        #1 chk("to_read_dropped", {31'd0, read}, 32'd0);
        wait_drain();
        waitrequest = 1'b0;
`endif

        repeat (3) @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
